// File: rtl/iic_target_regs_if.sv
// Signal bundle for the I2C register target: split SCL/SDA pad signals plus the host
// register port. The target uses the slave modport and the bus model uses the master modport.
interface iic_target_regs_if;
   logic       scl_i;
   logic       scl_o;
   logic       scl_t;
   logic       sda_i;
   logic       sda_o;
   logic       sda_t;
   logic       host_wr_en;
   logic [7:0] host_addr;
   logic [7:0] host_wr_data;
   logic [7:0] host_rd_data;
   logic       wr_strobe;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       busy;

   modport slave (
      input  scl_i, sda_i, host_wr_en, host_addr, host_wr_data,
      output scl_o, scl_t, sda_o, sda_t, host_rd_data, wr_strobe, wr_addr, wr_data, busy
   );

   modport master (
      output scl_i, sda_i, host_wr_en, host_addr, host_wr_data,
      input  scl_o, scl_t, sda_o, sda_t, host_rd_data, wr_strobe, wr_addr, wr_data, busy
   );
endinterface

// File: rtl/iic_target_regs.sv
// I2C target with a 256-byte register file, a host preload/inspect port and a commit strobe.
//
// state      | meaning
// IDLE       | bus free or after STOP
// ADDR       | shifting in the address byte
// ADDR_ACK   | ACK of the address, then branch on R/W
// PTR        | shifting in the register pointer
// PTR_ACK    | ACK of the pointer byte
// WRITE      | shifting in a data byte for mem[ptr]
// WRITE_ACK  | ACK of a data byte
// READ       | shifting out mem[ptr] on scl falls
// READ_ACK   | sampling the master ACK/NACK
// IGNORE     | not addressed or read ended; wait for START/STOP
module iic_target_regs #(
   parameter logic [6:0]  TARGET_ADDR = 7'h50,
   parameter int unsigned FILTER_LEN  = 3
) (
   input  logic             clock,
   input  logic             resetn,
   iic_target_regs_if.slave bus
);
   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_ADDR      = 4'd1;
   localparam logic [3:0] S_ADDR_ACK  = 4'd2;
   localparam logic [3:0] S_PTR       = 4'd3;
   localparam logic [3:0] S_PTR_ACK   = 4'd4;
   localparam logic [3:0] S_WRITE     = 4'd5;
   localparam logic [3:0] S_WRITE_ACK = 4'd6;
   localparam logic [3:0] S_READ      = 4'd7;
   localparam logic [3:0] S_READ_ACK  = 4'd8;
   localparam logic [3:0] S_IGNORE    = 4'd9;

   localparam logic [2:0] FILT_LOAD = 3'(FILTER_LEN - 1);

   logic [7:0] r_mem [256];

   logic       r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;
   logic       r_scl_f, r_sda_f;
   logic [2:0] r_scl_cnt, r_sda_cnt;
   logic       r_scl_rise, r_scl_fall, r_start, r_stop;
   logic       w_scl_acc, w_sda_acc;

   logic [3:0] r_state;
   logic [2:0] r_bit_cnt;
   logic [7:0] r_shift;
   logic [7:0] r_ptr;
   logic       r_rw;
   logic       r_ack_on;
   logic       r_msb_pend;
   logic       r_sda_t;
   logic       r_busy;
   logic       r_wr_strobe;
   logic [7:0] r_wr_addr, r_wr_data;
   logic [7:0] r_host_rd;

   logic [7:0] w_byte;
   logic [7:0] w_mem_at_ptr;
   logic       w_bus_we;

   // A new level is accepted once the down-counter reaches terminal count while the
   // synchronized input still disagrees with the filtered level.
   assign w_scl_acc = (r_scl_s2 != r_scl_f) && (r_scl_cnt == 3'd0);
   assign w_sda_acc = (r_sda_s2 != r_sda_f) && (r_sda_cnt == 3'd0);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_scl_s1   <= 1'b1;
         r_scl_s2   <= 1'b1;
         r_sda_s1   <= 1'b1;
         r_sda_s2   <= 1'b1;
         r_scl_f    <= 1'b1;
         r_sda_f    <= 1'b1;
         r_scl_cnt  <= FILT_LOAD;
         r_sda_cnt  <= FILT_LOAD;
         r_scl_rise <= 1'b0;
         r_scl_fall <= 1'b0;
         r_start    <= 1'b0;
         r_stop     <= 1'b0;
      end else begin
         r_scl_s1 <= bus.scl_i;
         r_scl_s2 <= r_scl_s1;
         r_sda_s1 <= bus.sda_i;
         r_sda_s2 <= r_sda_s1;

         if ((r_scl_s2 == r_scl_f) || w_scl_acc) r_scl_cnt <= FILT_LOAD;
         else                                    r_scl_cnt <= r_scl_cnt - 3'd1;
         if ((r_sda_s2 == r_sda_f) || w_sda_acc) r_sda_cnt <= FILT_LOAD;
         else                                    r_sda_cnt <= r_sda_cnt - 3'd1;

         if (w_scl_acc) r_scl_f <= r_scl_s2;
         if (w_sda_acc) r_sda_f <= r_sda_s2;

         r_scl_rise <= w_scl_acc && r_scl_s2;
         r_scl_fall <= w_scl_acc && !r_scl_s2;
         r_start    <= w_sda_acc && !r_sda_s2 && r_scl_f;
         r_stop     <= w_sda_acc && r_sda_s2 && r_scl_f;
      end
   end

   assign w_byte       = {r_shift[6:0], r_sda_f};
   assign w_mem_at_ptr = r_mem[r_ptr];
   assign w_bus_we     = (r_state == S_WRITE) && r_scl_rise && (r_bit_cnt == 3'd7)
                         && !r_start && !r_stop;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state     <= S_IDLE;
         r_bit_cnt   <= 3'd0;
         r_shift     <= 8'h00;
         r_ptr       <= 8'h00;
         r_rw        <= 1'b0;
         r_ack_on    <= 1'b0;
         r_msb_pend  <= 1'b0;
         r_sda_t     <= 1'b1;
         r_busy      <= 1'b0;
         r_wr_strobe <= 1'b0;
         r_wr_addr   <= 8'h00;
         r_wr_data   <= 8'h00;
      end else begin
         r_wr_strobe <= 1'b0;
         if (r_start || r_stop) begin
            r_state    <= r_start ? S_ADDR : S_IDLE;
            r_bit_cnt  <= 3'd0;
            r_ack_on   <= 1'b0;
            r_msb_pend <= 1'b0;
            r_sda_t    <= 1'b1;
            r_busy     <= 1'b0;
         end else begin
            case (r_state)
               S_ADDR: if (r_scl_rise) begin
                  r_shift   <= w_byte;
                  r_bit_cnt <= r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) begin
                     if (w_byte[7:1] == TARGET_ADDR) begin
                        r_state <= S_ADDR_ACK;
                        r_busy  <= 1'b1;
                        r_rw    <= w_byte[0];
                     end else begin
                        r_state <= S_IGNORE;
                     end
                  end
               end
               S_PTR: if (r_scl_rise) begin
                  r_shift   <= w_byte;
                  r_bit_cnt <= r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) begin
                     r_ptr   <= w_byte;
                     r_state <= S_PTR_ACK;
                  end
               end
               S_WRITE: if (r_scl_rise) begin
                  r_shift   <= w_byte;
                  r_bit_cnt <= r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) begin
                     r_wr_strobe <= 1'b1;
                     r_wr_addr   <= r_ptr;
                     r_wr_data   <= w_byte;
                     r_ptr       <= r_ptr + 8'd1;
                     r_state     <= S_WRITE_ACK;
                  end
               end
               S_ADDR_ACK, S_PTR_ACK, S_WRITE_ACK: if (r_scl_fall) begin
                  if (!r_ack_on) begin
                     r_ack_on <= 1'b1;
                     r_sda_t  <= 1'b0;
                  end else begin
                     r_ack_on <= 1'b0;
                     if ((r_state == S_ADDR_ACK) && r_rw) begin
                        r_state <= S_READ;
                        r_shift <= w_mem_at_ptr;
                        r_sda_t <= w_mem_at_ptr[7];
                     end else begin
                        r_sda_t <= 1'b1;
                        r_state <= (r_state == S_ADDR_ACK) ? S_PTR : S_WRITE;
                     end
                  end
               end
               S_READ: if (r_scl_fall) begin
                  if (r_msb_pend) begin
                     r_msb_pend <= 1'b0;
                     r_sda_t    <= r_shift[7];
                  end else if (r_bit_cnt == 3'd7) begin
                     r_bit_cnt <= 3'd0;
                     r_sda_t   <= 1'b1;
                     r_ptr     <= r_ptr + 8'd1;
                     r_state   <= S_READ_ACK;
                  end else begin
                     r_shift   <= {r_shift[6:0], 1'b0};
                     r_sda_t   <= r_shift[6];
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                  end
               end
               // After an ACK the next MSB waits for the coming scl fall.
               S_READ_ACK: if (r_scl_rise) begin
                  if (!r_sda_f) begin
                     r_shift    <= w_mem_at_ptr;
                     r_msb_pend <= 1'b1;
                     r_state    <= S_READ;
                  end else begin
                     r_state <= S_IGNORE;
                     r_busy  <= 1'b0;
                  end
               end
               S_IGNORE: begin
                  r_sda_t <= 1'b1;
                  r_busy  <= 1'b0;
               end
               default: r_sda_t <= 1'b1;
            endcase
         end
      end
   end

   // Bus write takes the port when both sides target the same address.
   always_ff @(posedge clock) begin
      if (w_bus_we) r_mem[r_ptr] <= w_byte;
      if (bus.host_wr_en && !(w_bus_we && (bus.host_addr == r_ptr)))
         r_mem[bus.host_addr] <= bus.host_wr_data;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) r_host_rd <= 8'h00;
      else         r_host_rd <= r_mem[bus.host_addr];
   end

   assign bus.scl_o        = 1'b0;
   assign bus.scl_t        = 1'b1;
   assign bus.sda_o        = 1'b0;
   assign bus.sda_t        = r_sda_t;
   assign bus.host_rd_data = r_host_rd;
   assign bus.wr_strobe    = r_wr_strobe;
   assign bus.wr_addr      = r_wr_addr;
   assign bus.wr_data      = r_wr_data;
   assign bus.busy         = r_busy;
endmodule

// File: tb/tb_iic_target_regs.sv
// Directed bench: a bit-banged I2C master with open-drain SDA exercises the register target.
module tb_iic_target_regs;
   logic clock  = 1'b0;
   logic resetn = 1'b0;
   logic scl_m  = 1'b1;
   logic sda_m  = 1'b1;

   int checks      = 0;
   int failures    = 0;
   int ws_cnt      = 0;
   int sda_low_cnt = 0;
   int busy_cnt    = 0;
   logic [7:0] ws_addr [64];
   logic [7:0] ws_data [64];

   iic_target_regs_if bus ();

   iic_target_regs #(.TARGET_ADDR(7'h50), .FILTER_LEN(3)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clock = ~clock;

   assign bus.scl_i = scl_m;
   assign bus.sda_i = sda_m & bus.sda_t;

   always @(negedge clock) begin
      if (bus.wr_strobe) begin
         if (ws_cnt < 64) begin
            ws_addr[ws_cnt] = bus.wr_addr;
            ws_data[ws_cnt] = bus.wr_data;
         end
         ws_cnt = ws_cnt + 1;
      end
      if (!bus.sda_t) sda_low_cnt = sda_low_cnt + 1;
      if (bus.busy)   busy_cnt    = busy_cnt + 1;
   end

   task automatic wait_q();
      repeat (8) @(negedge clock);
   endtask

   task automatic bit_xfer(input logic b, output logic s);
      sda_m = b;
      wait_q();
      scl_m = 1'b1;
      wait_q();
      s = bus.sda_i;
      wait_q();
      scl_m = 1'b0;
      wait_q();
   endtask

   task automatic start_c();
      sda_m = 1'b1;
      wait_q();
      scl_m = 1'b1;
      wait_q();
      sda_m = 1'b0;
      wait_q();
      scl_m = 1'b0;
      wait_q();
   endtask

   task automatic stop_c();
      sda_m = 1'b0;
      wait_q();
      scl_m = 1'b1;
      wait_q();
      sda_m = 1'b1;
      wait_q();
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
      bit_xfer(1'b1, s);
      ack = (s == 1'b0);
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bit_xfer(1'b1, s);
         d[i] = s;
      end
      bit_xfer(nack, s);
   endtask

   task automatic host_write(input logic [7:0] a, input logic [7:0] d);
      @(negedge clock);
      bus.host_addr    = a;
      bus.host_wr_data = d;
      bus.host_wr_en   = 1'b1;
      @(negedge clock);
      bus.host_wr_en   = 1'b0;
   endtask

   task automatic host_read(input logic [7:0] a, output logic [7:0] d);
      @(negedge clock);
      bus.host_addr = a;
      @(negedge clock);
      d = bus.host_rd_data;
   endtask

   task automatic test_reset();
      bus.host_wr_en   = 1'b0;
      bus.host_addr    = 8'h00;
      bus.host_wr_data = 8'h00;
      resetn = 1'b0;
      repeat (3) @(negedge clock);
      checks++; if (bus.sda_t !== 1'b1) begin failures++; $display("FAIL rst_sda_t got=%b exp=1", bus.sda_t); end
      checks++; if (bus.scl_t !== 1'b1) begin failures++; $display("FAIL rst_scl_t got=%b exp=1", bus.scl_t); end
      checks++; if (bus.scl_o !== 1'b0) begin failures++; $display("FAIL rst_scl_o got=%b exp=0", bus.scl_o); end
      checks++; if (bus.sda_o !== 1'b0) begin failures++; $display("FAIL rst_sda_o got=%b exp=0", bus.sda_o); end
      checks++; if (bus.wr_strobe !== 1'b0) begin failures++; $display("FAIL rst_wr_strobe got=%b exp=0", bus.wr_strobe); end
      checks++; if (bus.wr_addr !== 8'h00) begin failures++; $display("FAIL rst_wr_addr got=%h exp=00", bus.wr_addr); end
      checks++; if (bus.wr_data !== 8'h00) begin failures++; $display("FAIL rst_wr_data got=%h exp=00", bus.wr_data); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.host_rd_data !== 8'h00) begin failures++; $display("FAIL rst_host_rd got=%h exp=00", bus.host_rd_data); end
      checks++; if (dut.r_ptr !== 8'h00) begin failures++; $display("FAIL rst_ptr got=%h exp=00", dut.r_ptr); end
      checks++; if (dut.r_state !== 4'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", dut.r_state); end
      resetn = 1'b1;
      repeat (4) @(negedge clock);
      for (int a = 0; a < 256; a++) host_write(8'(a), 8'h00);
   endtask

   task automatic test_write();
      logic       ack;
      logic [7:0] d;
      logic [7:0] tx [4] = '{8'hA0, 8'h10, 8'h55, 8'hAA};
      int         base = ws_cnt;
      start_c();
      for (int i = 0; i < 4; i++) begin
         write_byte(tx[i], ack);
         checks++; if (ack !== 1'b1) begin failures++; $display("FAIL wr_ack%0d got=%b exp=1", i, ack); end
         if (i == 0) begin
            checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL wr_busy got=%b exp=1", bus.busy); end
         end
      end
      stop_c();
      repeat (4) @(negedge clock);
      checks++;
      if ((ws_cnt - base) != 2 || ws_addr[base] !== 8'h10 || ws_data[base] !== 8'h55
          || ws_addr[base+1] !== 8'h11 || ws_data[base+1] !== 8'hAA) begin
         failures++;
         $display("FAIL wr_strobes got n=%0d (%h,%h)(%h,%h) exp n=2 (10,55)(11,aa)", ws_cnt - base,
                  ws_addr[base], ws_data[base], ws_addr[base+1], ws_data[base+1]);
      end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL wr_busy_stop got=%b exp=0", bus.busy); end
      host_read(8'h10, d);
      checks++; if (d !== 8'h55) begin failures++; $display("FAIL wr_mem10 got=%h exp=55", d); end
      host_read(8'h11, d);
      checks++; if (d !== 8'hAA) begin failures++; $display("FAIL wr_mem11 got=%h exp=aa", d); end
   endtask

   task automatic test_random_read();
      logic       ack;
      logic [7:0] d;
      host_write(8'h20, 8'h3C);
      host_write(8'h21, 8'hC3);
      start_c();
      write_byte(8'hA0, ack);
      write_byte(8'h20, ack);
      start_c();
      write_byte(8'hA1, ack);
      checks++; if (ack !== 1'b1) begin failures++; $display("FAIL rd_addr_ack got=%b exp=1", ack); end
      read_byte(1'b0, d);
      checks++; if (d !== 8'h3C) begin failures++; $display("FAIL rd_byte0 got=%h exp=3c", d); end
      read_byte(1'b1, d);
      checks++; if (d !== 8'hC3) begin failures++; $display("FAIL rd_byte1 got=%h exp=c3", d); end
      checks++; if (bus.sda_t !== 1'b1) begin failures++; $display("FAIL rd_nack_release got=%b exp=1", bus.sda_t); end
      checks++; if (dut.r_state !== 4'd9) begin failures++; $display("FAIL rd_nack_state got=%0d exp=9", dut.r_state); end
      stop_c();
      checks++; if (dut.r_ptr !== 8'h22) begin failures++; $display("FAIL rd_ptr got=%h exp=22", dut.r_ptr); end
   endtask

   task automatic test_mismatch();
      logic ack;
      int   acks = 0;
      int   ws0  = ws_cnt;
      int   lo0  = sda_low_cnt;
      int   bz0  = busy_cnt;
      logic [7:0] tx [4] = '{8'hA2, 8'h10, 8'h66, 8'h77};
      start_c();
      for (int i = 0; i < 4; i++) begin
         write_byte(tx[i], ack);
         if (ack) acks++;
      end
      stop_c();
      repeat (4) @(negedge clock);
      checks++; if (acks != 0) begin failures++; $display("FAIL mm_acks got=%0d exp=0", acks); end
      checks++; if (sda_low_cnt != lo0) begin failures++; $display("FAIL mm_sda_low got=%0d exp=0 cycles", sda_low_cnt - lo0); end
      checks++; if (busy_cnt != bz0) begin failures++; $display("FAIL mm_busy got=%0d exp=0 cycles", busy_cnt - bz0); end
      checks++; if (ws_cnt != ws0) begin failures++; $display("FAIL mm_strobe got=%0d exp=0", ws_cnt - ws0); end
   endtask

   task automatic test_wrap();
      logic       ack;
      logic [7:0] d;
      int         base;
      host_write(8'h01, 8'h5A);
      base = ws_cnt;
      start_c();
      write_byte(8'hA0, ack);
      write_byte(8'hFF, ack);
      write_byte(8'h11, ack);
      write_byte(8'h22, ack);
      stop_c();
      repeat (4) @(negedge clock);
      checks++;
      if ((ws_cnt - base) != 2 || ws_addr[base] !== 8'hFF || ws_data[base] !== 8'h11
          || ws_addr[base+1] !== 8'h00 || ws_data[base+1] !== 8'h22) begin
         failures++;
         $display("FAIL wrap_strobes got n=%0d (%h,%h)(%h,%h) exp n=2 (ff,11)(00,22)", ws_cnt - base,
                  ws_addr[base], ws_data[base], ws_addr[base+1], ws_data[base+1]);
      end
      host_read(8'hFF, d);
      checks++; if (d !== 8'h11) begin failures++; $display("FAIL wrap_memff got=%h exp=11", d); end
      host_read(8'h00, d);
      checks++; if (d !== 8'h22) begin failures++; $display("FAIL wrap_mem00 got=%h exp=22", d); end
      start_c();
      write_byte(8'hA1, ack);
      read_byte(1'b1, d);
      stop_c();
      checks++; if (d !== 8'h5A) begin failures++; $display("FAIL wrap_cur_read got=%h exp=5a", d); end
   endtask

   task automatic test_abort();
      logic       ack;
      logic       s;
      logic [7:0] d;
      logic [7:0] pat = 8'hA5;
      int         base = ws_cnt;
      start_c();
      write_byte(8'hA0, ack);
      write_byte(8'h40, ack);
      for (int i = 7; i >= 4; i--) bit_xfer(pat[i], s);
      stop_c();
      repeat (4) @(negedge clock);
      checks++; if (ws_cnt != base) begin failures++; $display("FAIL abort_strobe got=%0d exp=0", ws_cnt - base); end
      checks++; if (dut.r_state !== 4'd0) begin failures++; $display("FAIL abort_state got=%0d exp=0", dut.r_state); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
      host_read(8'h40, d);
      checks++; if (d !== 8'h00) begin failures++; $display("FAIL abort_mem40 got=%h exp=00", d); end
   endtask

   task automatic test_collision();
      logic       ack;
      logic       s;
      logic [7:0] d;
      logic [7:0] dat = 8'h77;
      start_c();
      write_byte(8'hA0, ack);
      write_byte(8'h30, ack);
      for (int i = 7; i >= 1; i--) bit_xfer(dat[i], s);
      sda_m = dat[0];
      wait_q();
      scl_m = 1'b1;
      repeat (5) @(negedge clock);
      bus.host_addr    = 8'h30;
      bus.host_wr_data = 8'h99;
      bus.host_wr_en   = 1'b1;
      @(negedge clock);
      bus.host_wr_en   = 1'b0;
      checks++; if (bus.wr_strobe !== 1'b1) begin failures++; $display("FAIL coll_align got=%b exp=1", bus.wr_strobe); end
      repeat (2) @(negedge clock);
      wait_q();
      scl_m = 1'b0;
      wait_q();
      bit_xfer(1'b1, s);
      checks++; if (s !== 1'b0) begin failures++; $display("FAIL coll_ack got=%b exp=0", s); end
      stop_c();
      host_read(8'h30, d);
      checks++; if (d !== 8'h77) begin failures++; $display("FAIL coll_mem30 got=%h exp=77", d); end
   endtask

   task automatic test_reset_mid_ack();
      logic       s;
      logic [7:0] a = 8'hA0;
      start_c();
      for (int i = 7; i >= 0; i--) bit_xfer(a[i], s);
      repeat (2) @(negedge clock);
      checks++; if (bus.sda_t !== 1'b0) begin failures++; $display("FAIL rma_ack_driven got=%b exp=0", bus.sda_t); end
      resetn = 1'b0;
      #1;
      checks++; if (bus.sda_t !== 1'b1) begin failures++; $display("FAIL rma_sda_t got=%b exp=1", bus.sda_t); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rma_busy got=%b exp=0", bus.busy); end
      @(negedge clock);
      resetn = 1'b1;
      stop_c();
      repeat (4) @(negedge clock);
   endtask

   initial begin
      test_reset();
      test_write();
      test_random_read();
      test_mismatch();
      test_wrap();
      test_abort();
      test_collision();
      test_reset_mid_ack();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/iic_target_regs.md
# iic_target_regs

I2C target (responder) with a 256-byte register file, for the side of the bus opposite the main IIC controller. It lets the RISC-V IIC master be closed-loop tested, and it can also emulate a QSFP/EEPROM management target on a spare bus. The bus side uses split scl/sda _i/_o/_t signals, and the board IOBUF sits outside this block. A host port preloads and inspects registers, and a strobe reports every committed bus write.

## Interface
- TARGET_ADDR, 7'h50: 7-bit target address.
- FILTER_LEN, 3: consecutive identical samples required to accept a new SCL/SDA level (glitch filter), range 1-8.
- clock  in  1  system clock; must be at least 16x the SCL rate.
- resetn  in  1  reset; one clock, reset is asynchronous and active-low.
- scl_i  in  1  SCL from the pad.
- scl_o  out  1  constant 0.
- scl_t  out  1  constant 1 (no clock stretching).
- sda_i  in  1  SDA from the pad.
- sda_o  out  1  constant 0.
- sda_t  out  1  1 = release SDA, 0 = pull SDA low.
- host_wr_en  in  1  host write strobe.
- host_addr  in  8  host register address.
- host_wr_data  in  8  host write data.
- host_rd_data  out  8  mem[host_addr], registered.
- wr_strobe  out  1  one-cycle pulse per committed bus write.
- wr_addr  out  8  register address of the committed bus write.
- wr_data  out  8  data of the committed bus write.
- busy  out  1  high from an address-matched START until the next STOP or START.

## Operation
- **Input conditioning:** scl_i and sda_i each pass through a 2-flop synchronizer, then the FILTER_LEN filter. This produces scl_f and sda_f, plus one-cycle events scl_rise and scl_fall.
- **Bus conditions:**
  - START: sda_f falls while scl_f is high.
  - STOP: sda_f rises while scl_f is high.
  - START or STOP has priority over every state. It aborts the current byte and releases SDA.
  - START enters ADDR (repeated START included). STOP enters IDLE.
- **States:** IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE.
- **Shifting:** a 3-bit bit counter plus an 8-bit shift register, MSB first. Bits are sampled on scl_rise.
- **ADDR:**
  - After 8 bits, compare shift[7:1] with TARGET_ADDR.
  - On match, go to ADDR_ACK and set busy.
  - On mismatch, go to IGNORE.
- **ADDR_ACK:**
  - On the scl_fall that ends bit 8, drive sda_t=0.
  - On the next scl_fall, release SDA.
  - Then go to PTR if R/W=0, or to READ if R/W=1.
  - When entering READ, load mem[ptr] and drive its MSB immediately.
- **PTR:** after 8 bits, ptr ← byte, then PTR_ACK (ACK as above), then WRITE.
- **WRITE:**
  - After 8 bits, write mem[ptr] ← byte and assert wr_strobe with wr_addr=ptr and wr_data=byte.
  - Then ptr ← ptr+1, modulo 256 (255 wraps to 0).
  - Then WRITE_ACK (ACK), then WRITE.
- **READ:**
  - Each bit is presented on scl_fall: sda_t = bit (1 releases, 0 drives low).
  - After the 8th bit, release SDA at the following scl_fall and go to READ_ACK.
  - ptr increments (with wrap) after each byte is transmitted.
- **READ_ACK:** the master's bit is sampled on scl_rise.
  - 0 (ACK): reload mem[ptr] and return to READ.
  - 1 (NACK): go to IGNORE.
- **IGNORE:** sda_t=1 and busy=0; wait for START or STOP.
- **Register pointer:**
  - ptr persists across transactions, so a read without a pointer byte continues from the current ptr.
  - Reset value of ptr is 0.
- **Host port:**
  - Writes mem[host_addr] on the clock after host_wr_en.
  - If host and bus write the same address in the same cycle, the bus write wins and the host write is dropped.
  - A host write to mem[ptr] during READ is not reflected in a byte already loaded.
- **Memory:** not reset; initial contents are undefined, and the bench preloads them through the host port.

## Timing
- **Reset values:** sda_t=1, sda_o=0, scl_o=0, scl_t=1, wr_strobe=0, wr_addr=0, wr_data=0, busy=0, host_rd_data=0, state=IDLE, ptr=0.
- **Reset assertion:** SDA is released combinationally through the async reset, even mid-byte.
- **Bus-event latency:** 2+FILTER_LEN clocks from pad edge to scl_rise, scl_fall, START or STOP.
- **SDA output:** sda_t changes on the clock after the detected scl_fall, i.e. 3+FILTER_LEN clocks after the pad falling edge.
- **Write commit:** wr_strobe is asserted on the clock after the scl_rise of the 8th data bit. The memory write occurs in the same cycle.
- **host_rd_data:** 1-clock latency from host_addr.
- **busy:**
  - Rises on the clock after the address-match decision.
  - Falls on the clock after a STOP, or after a START / IGNORE entry.

## Test plan
- **Write:** preload 0; bus sends START, 0xA0, 0x10, 0x55, 0xAA, STOP.
  - Target ACKs all 4 bytes.
  - wr_strobe fires twice: (0x10,0x55) then (0x11,0xAA).
  - host_rd_data at 0x10 reads 0x55 and at 0x11 reads 0xAA.
- **Random read:** preload mem[0x20]=0x3C, mem[0x21]=0xC3; bus sends START, 0xA0, 0x20, repeated START, 0xA1, reads 2 bytes with ACK then NACK, STOP.
  - Data reads 0x3C then 0xC3.
  - ptr=0x22 afterwards.
  - SDA is released after the NACK.
- **Address mismatch:** START, 0xA2, 3 further bytes, STOP.
  - sda_t stays 1 throughout.
  - busy=0 and no wr_strobe.
- **Wrap:** write pointer 0xFF, then data 0x11, 0x22.
  - Writes land at 0xFF and then 0x00.
  - A subsequent current-address read returns mem[0x01].
- **Abort and reset:**
  - STOP injected after 4 data bits of a write: no wr_strobe, state IDLE.
  - resetn pulsed low while the target drives ACK: sda_t=1 within the same cycle, busy=0.
- **Collision:** host_wr_en to 0x30 with data 0x99 in the same cycle as a bus write of 0x77 to 0x30: mem[0x30]=0x77.
